// File: rtl/clock_disp_pkg.sv
// Shared definitions for the clock display scanner: FSM state encoding,
// digit-index constants and active-low 7-segment patterns ({g,f,e,d,c,b,a}).
package clock_disp_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } disp_state_t;

  // Digit positions, left to right on the display
  localparam logic [2:0] DIG_HT = 3'd0;  // hours tens
  localparam logic [2:0] DIG_HO = 3'd1;  // hours ones
  localparam logic [2:0] DIG_MT = 3'd2;  // minutes tens
  localparam logic [2:0] DIG_MO = 3'd3;  // minutes ones
  localparam logic [2:0] DIG_ST = 3'd4;  // seconds tens
  localparam logic [2:0] DIG_SO = 3'd5;  // seconds ones

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  // One frame's worth of time, frozen so the display never tears
  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       pm;
  } time_snap_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Non-decimal nibbles show a dash; blank forces all segments off.
module bcd_to_7seg
  import clock_disp_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);

  // Pattern lookup, blank overriding everything
  always_comb begin
    seg = SEG_DASH;
    unique case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    if (blank) seg = SEG_BLANK;
  end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed 7-segment scanner for the 12-hour clock BCD bus.
// Snapshots {hh,mm,ss,pm} once per frame, then cycles BLANK/SHOW per digit.
// Optional macro DISP_DIM_EN adds a 4-bit bright input that PWMs segments in SHOW.
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int unsigned DWELL_CYC = 16,
  parameter int unsigned BLANK_CYC = 2,
  parameter int unsigned LZB       = 1
)(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ena,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       pm,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
`ifdef DISP_DIM_EN
  ,input logic [3:0] bright
`endif
);

  localparam int unsigned MAXC  = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int unsigned CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);

  disp_state_t      state, state_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  time_snap_t       snap, snap_nxt;
  logic             cap;
  logic [3:0]       nibble;
  logic             dig_blank;
  logic             lit;
  logic [6:0]       seg_pat;

  // Next-state, snapshot capture and next-cycle digit selection.
  // Outputs are registered from the *next* state so they line up with it exactly.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    if (!ena) begin
      state_nxt = ST_BLANK;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      unique case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt = ST_SHOW;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt == DWELL_LAST) begin
            state_nxt = ST_BLANK;
            cnt_nxt   = '0;
            idx_nxt   = (idx == DIG_SO) ? DIG_HT : 3'(idx + 3'd1);
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = ST_BLANK;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end

    cap      = (state == ST_BLANK) && (idx == DIG_HT) && (cnt == '0) && ena;
    // Bypass the fresh capture so a 1-cycle BLANK still shows the new snapshot
    snap_nxt = cap ? {hh, mm, ss, pm} : snap;

    unique case (idx_nxt)
      DIG_HT:  nibble = snap_nxt.hh[7:4];
      DIG_HO:  nibble = snap_nxt.hh[3:0];
      DIG_MT:  nibble = snap_nxt.mm[7:4];
      DIG_MO:  nibble = snap_nxt.mm[3:0];
      DIG_ST:  nibble = snap_nxt.ss[7:4];
      default: nibble = snap_nxt.ss[3:0];
    endcase

    // Leading-zero blanking keeps an[0] driven so every digit has the same duty
    dig_blank = (LZB != 0) && (idx_nxt == DIG_HT) && (nibble == 4'd0);

`ifdef DISP_DIM_EN
    lit = (4'(cnt_nxt) <= bright);
`else
    lit = 1'b1;
`endif
  end

  bcd_to_7seg u_dec (
    .nib   (nibble),
    .blank (dig_blank),
    .seg   (seg_pat)
  );

  // State, snapshot and registered display outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_BLANK;
      idx         <= '0;
      cnt         <= '0;
      snap        <= '0;
      an          <= 6'h3F;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      snap        <= snap_nxt;
      frame_start <= cap;
      if (state_nxt == ST_SHOW) begin
        an  <= ~(6'b000001 << idx_nxt);
        seg <= lit ? seg_pat : SEG_BLANK;
        dp  <= ~(lit && (idx_nxt == DIG_SO) && snap_nxt.pm);
      end else begin
        an  <= 6'h3F;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end
    end
  end

endmodule
